// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: sequences one UART frame (start, 8 data LSB-first, optional parity, stop) per accepted byte
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   tx_data    byte to send, sampled only at the handshake
//   tx_valid   tx_data is valid
//   tx_ready   controller can accept a byte (combinational, high only in IDLE)
//   tx         registered serial line, idle high
//   busy       registered, frame in progress
//   frame_done registered one-cycle pulse on the last cycle of the final stop bit
module uart_tx_ctrl #(
    parameter int BIT_TIME  = 5208,
    parameter int N         = 13,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
    output logic       busy,
    output logic       frame_done
);
    localparam logic [N-1:0] BT       = N'(BIT_TIME);
    localparam logic         PAR_EN   = PARITY == 1 || PARITY == 2;
    localparam logic         ODD      = PARITY == 2;
    localparam logic         TWO_STOP = STOP_BITS == 2;

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    state_t       state;
    logic [N-1:0] timer;
    logic [7:0]   shift;
    logic [2:0]   idx;
    logic         stop_cnt;
    logic         par;
    logic         bit_end;
    logic         last_stop;
    logic         enter_final;
    logic         fd_set;

    assign tx_ready  = state == IDLE;
    assign bit_end   = timer == '0;
    assign last_stop = !TWO_STOP || stop_cnt;
    // With a zero bit timer the final stop cycle is also its first, so the pulse is raised on entry
    assign enter_final = bit_end && ((state == STOP && !last_stop) ||
                         (!TWO_STOP && (state == PAR || (state == DATA && idx == 3'd7 && !PAR_EN))));
    assign fd_set = (state == STOP && last_stop && timer == N'(1)) || (BIT_TIME == 0 && enter_final);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            timer      <= BT;
            shift      <= '0;
            idx        <= '0;
            stop_cnt   <= 1'b0;
            par        <= 1'b0;
            tx         <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= fd_set;
            timer      <= (state == IDLE || bit_end) ? BT : timer - N'(1);
            case (state)
                IDLE: if (tx_valid) begin
                    state <= START;
                    shift <= tx_data;
                    // parity is fixed from the latched byte because the shift register is consumed
                    par   <= ^tx_data ^ ODD;
                    tx    <= 1'b0;
                    busy  <= 1'b1;
                end
                START: if (bit_end) begin
                    state <= DATA;
                    idx   <= '0;
                    tx    <= shift[0];
                end
                DATA: if (bit_end) begin
                    shift <= shift >> 1;
                    idx   <= idx + 3'd1;
                    if (idx == 3'd7) begin
                        state    <= PAR_EN ? PAR : STOP;
                        tx       <= PAR_EN ? par : 1'b1;
                        stop_cnt <= 1'b0;
                    end else begin
                        tx <= shift[1];
                    end
                end
                PAR: if (bit_end) begin
                    state    <= STOP;
                    tx       <= 1'b1;
                    stop_cnt <= 1'b0;
                end
                STOP: if (bit_end) begin
                    if (last_stop) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        stop_cnt <= 1'b0;
                    end else begin
                        stop_cnt <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl: scoreboard bench for uart_tx_ctrl over three frame formats
module tb_uart_tx_ctrl;
    localparam int BT = 3;

    typedef struct {
        logic [7:0] b;
        int         h;
    } ent_t;

    logic clk = 1'b0;
    int   cyc = 0;
    int   vec = 0;
    int   err = 0;
    int   done = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar i = 0; i < 3; i++) begin : g
        localparam int S = (i == 1) ? 2 : 1;
        logic       rst;
        logic       v;
        logic       r;
        logic       tx;
        logic       busy;
        logic       fd;
        logic [7:0] d;
        ent_t       q[$];

        uart_tx_ctrl #(.BIT_TIME(BT), .N(4), .PARITY(i), .STOP_BITS(S)) dut (
            .clk(clk), .rst(rst), .tx_data(d), .tx_valid(v),
            .tx_ready(r), .tx(tx), .busy(busy), .frame_done(fd)
        );

        task automatic idle(input int n);
            repeat (n) begin
                @(negedge clk);
                v = 1'b0;
                d = 8'($urandom);
            end
        endtask

        task automatic xmit(input logic [7:0] b);
            for (int k = 0; k < 200; k++) begin
                @(negedge clk);
                if (r) begin
                    d = b;
                    v = 1'b1;
                    q.push_back('{b, cyc});
                    @(posedge clk);
                    return;
                end
                d = 8'($urandom);
                v = 1'($urandom);
            end
            vec++;
            err++;
            $display("FAIL inst%0d handshake_timeout byte %h: ready stayed %b, required 1", i, b, r);
        endtask

        task automatic chk_reset(input string nm);
            vec++;
            if (tx !== 1'b1 || r !== 1'b1 || busy !== 1'b0 || fd !== 1'b0) begin
                err++;
                $display("FAIL inst%0d %s: tx=%b ready=%b busy=%b done=%b, required 1 1 0 0", i, nm, tx, r, busy, fd);
            end
        endtask

        initial begin : drv
            rst = 1'b0;
            v = 1'b0;
            d = 8'h00;
            repeat (3) @(negedge clk);
            chk_reset("reset_state");
            rst = 1'b1;
            xmit(8'h55);
            idle(3);
            xmit(8'h07);
            idle(2);
            xmit(8'hFF);
            idle(4);
            xmit(8'hA5);
            xmit(8'h3C);
            idle(3);
            xmit(8'hC3);
            repeat (4 * (BT + 1) + 1) @(negedge clk);
            #2 rst = 1'b0;
            v = 1'b0;
            #1 chk_reset("async_reset_mid_data");
            repeat (3) @(negedge clk);
            rst = 1'b1;
            idle(2);
            xmit(8'h81);
            idle(3);
            for (int n = 0; n < 15; n++) begin
                xmit(8'($urandom));
                if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 5));
            end
            idle(60);
            done++;
        end

        initial begin : mon
            logic bits[12];
            int   len;
            int   w;
            ent_t e;
            bit   bad;
            bit   ab;
            logic exp_fd;
            logic [3:0] seen;
            w = 0;
            forever begin
                @(negedge clk);
                if (!rst) begin
                    w = 0;
                    continue;
                end
                if (q.size() == 0) begin
                    if (tx !== 1'b1) begin
                        vec++;
                        err++;
                        $display("FAIL inst%0d extra_frame: tx=%b with nothing queued, required 1", i, tx);
                    end
                    continue;
                end
                if (tx !== 1'b0) begin
                    w++;
                    if (w > 3) begin
                        vec++;
                        err++;
                        $display("FAIL inst%0d start_timeout byte %h: tx=%b, required 0", i, q[0].b, tx);
                        void'(q.pop_front());
                        w = 0;
                    end
                    continue;
                end
                w = 0;
                e = q.pop_front();
                vec++;
                if (cyc != e.h + 1) begin
                    err++;
                    $display("FAIL inst%0d start_latency byte %h: start in cycle %0d, required %0d", i, e.b, cyc, e.h + 1);
                end
                bits[0] = 1'b0;
                for (int k = 0; k < 8; k++) bits[1 + k] = e.b[k];
                len = 9;
                if (i != 0) begin
                    bits[len] = (i == 1) ? ^e.b : ~^e.b;
                    len++;
                end
                for (int s = 0; s < S; s++) begin
                    bits[len] = 1'b1;
                    len++;
                end
                ab = 1'b0;
                for (int j = 0; j < len && !ab; j++) begin
                    bad = 1'b0;
                    seen = 4'b0;
                    for (int c = 0; c <= BT && !ab; c++) begin
                        if (j > 0 || c > 0) @(negedge clk);
                        exp_fd = (j == len - 1 && c == BT);
                        if (!rst) ab = 1'b1;
                        else if (tx !== bits[j] || r !== 1'b0 || busy !== 1'b1 || fd !== exp_fd) begin
                            if (!bad) seen = {tx, r, busy, fd};
                            bad = 1'b1;
                        end
                    end
                    if (!ab) begin
                        vec++;
                        if (bad) begin
                            err++;
                            $display("FAIL inst%0d frame byte %h bit%0d: tx/ready/busy/done=%b, required tx=%b ready=0 busy=1 done=%b",
                                     i, e.b, j, seen, bits[j], 1'(j == len - 1));
                        end
                    end
                end
                if (!ab) begin
                    @(negedge clk);
                    if (rst) begin
                        vec++;
                        if (r !== 1'b1 || tx !== 1'b1 || fd !== 1'b0 || busy !== 1'b0) begin
                            err++;
                            $display("FAIL inst%0d post_frame byte %h: ready=%b tx=%b done=%b busy=%b, required 1 1 0 0",
                                     i, e.b, r, tx, fd, busy);
                        end
                    end
                end
            end
        end
    end

    initial begin
        for (int k = 0; k < 30000 && done < 3; k++) @(posedge clk);
        if (done < 3) begin
            vec++;
            err++;
            $display("FAIL run_timeout: %0d instances finished, required 3", done);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end
endmodule
